tile_reset_sequencer: RTL and testbench

//  Multi-hart successor to the single-core wake-up counter and reset synchronizer in the tile core wrapper.
//  It gates the tile reset with a parametrised wake-up delay, then releases NUM_HARTS core resets in sequence.

---
 rtl/tile_reset_sequencer.sv | 167 ++++++++++++++++
 tb/tb_tile_reset_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_reset_sequencer.sv
// Tile reset sequencer: wake-up delay, per-hart reset release and soft-reset service.
// Optional macro TILE_RST_STAGGER_EN staggers hart releases by STAGGER_CYCLES.
module tile_reset_sequencer #(
  parameter int NUM_HARTS       = 1,
  parameter int WAKE_CNT_W      = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int STAGGER_CYCLES  = 4,
  parameter int SOFT_RST_CYCLES = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_l,
  input  logic [NUM_HARTS-1:0] soft_rst_req_i,
  output logic [NUM_HARTS-1:0] soft_rst_ack_o,
  output logic [NUM_HARTS-1:0] hart_rst_n_o,
  output logic                 boot_done_o,
  output logic                 all_released_o
);

  localparam int HOLD_W = (SOFT_RST_CYCLES > 1) ? $clog2(SOFT_RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SOFT_RST_CYCLES - 1);

  if (NUM_HARTS < 1 || NUM_HARTS > 16 || WAKE_CNT_W < 1 || SYNC_STAGES < 2 ||
      STAGGER_CYCLES < 1 || SOFT_RST_CYCLES < 1) begin : g_param_err
    $error("tile_reset_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {G_WAKE, G_RELEASE, G_RUN} gstate_e;
  typedef enum logic {H_IDLE, H_HOLD} hstate_e;

  gstate_e               gstate_q;
  hstate_e               hstate_q [NUM_HARTS];
  logic [HOLD_W-1:0]     hold_q   [NUM_HARTS];
  logic [WAKE_CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_HARTS-1:0]  pre_n_q;
  logic [NUM_HARTS-1:0]  req_q;
  logic [NUM_HARTS-1:0]  req_rise;
  logic [NUM_HARTS-1:0]  ack_q;
  logic                  boot_done_q;
  logic                  wake_fire;

`ifdef TILE_RST_STAGGER_EN
  localparam int IDX_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam int STG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HARTS - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER_CYCLES - 1);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  logic [STG_W-1:0] stg_q;

  assign idx_nxt = idx_q + IDX_W'(1);
`endif

  // The counter saturates on its MSB; release fires on the edge that sets it.
  always_comb begin
    cnt_d     = cnt_q[WAKE_CNT_W-1] ? cnt_q : cnt_q + WAKE_CNT_W'(1);
    wake_fire = cnt_d[WAKE_CNT_W-1];
    req_rise  = soft_rst_req_i & ~req_q;
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      gstate_q    <= G_WAKE;
      cnt_q       <= '0;
      pre_n_q     <= '0;
      req_q       <= '0;
      ack_q       <= '0;
      boot_done_q <= 1'b0;
`ifdef TILE_RST_STAGGER_EN
      idx_q       <= '0;
      stg_q       <= '0;
`endif
      for (int h = 0; h < NUM_HARTS; h++) begin
        hstate_q[h] <= H_IDLE;
        hold_q[h]   <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      req_q <= soft_rst_req_i;
      ack_q <= '0;
      case (gstate_q)
        G_WAKE: begin
          if (wake_fire) begin
`ifdef TILE_RST_STAGGER_EN
            pre_n_q[0] <= 1'b1;
            idx_q      <= '0;
            stg_q      <= '0;
            if (NUM_HARTS == 1) begin
              gstate_q    <= G_RUN;
              boot_done_q <= 1'b1;
            end else begin
              gstate_q <= G_RELEASE;
            end
`else
            pre_n_q     <= '1;
            gstate_q    <= G_RUN;
            boot_done_q <= 1'b1;
`endif
          end
        end
`ifdef TILE_RST_STAGGER_EN
        G_RELEASE: begin
          if (stg_q == STG_LAST) begin
            stg_q            <= '0;
            idx_q            <= idx_nxt;
            pre_n_q[idx_nxt] <= 1'b1;
            if (idx_nxt == LAST_IDX) begin
              gstate_q    <= G_RUN;
              boot_done_q <= 1'b1;
            end
          end else begin
            stg_q <= stg_q + STG_W'(1);
          end
        end
`endif
        G_RUN: begin
          // Each hart runs its own IDLE/HOLD machine; edges during HOLD are dropped.
          for (int h = 0; h < NUM_HARTS; h++) begin
            case (hstate_q[h])
              H_IDLE: begin
                if (req_rise[h]) begin
                  hstate_q[h] <= H_HOLD;
                  pre_n_q[h]  <= 1'b0;
                  hold_q[h]   <= HOLD_INIT;
                end
              end
              H_HOLD: begin
                if (hold_q[h] == '0) begin
                  hstate_q[h] <= H_IDLE;
                  pre_n_q[h]  <= 1'b1;
                  ack_q[h]    <= 1'b1;
                end else begin
                  hold_q[h] <= hold_q[h] - HOLD_W'(1);
                end
              end
              default: hstate_q[h] <= H_IDLE;
            endcase
          end
        end
        default: gstate_q <= G_WAKE;
      endcase
    end
  end

  // Per-hart synchronizer: cleared asynchronously by the tile reset or its own pre_n.
  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_sync
    logic                   ar_n;
    logic [SYNC_STAGES-1:0] sync_q;

    assign ar_n = reset_l & pre_n_q[h];

    always_ff @(posedge clk_i or negedge ar_n) begin
      if (!ar_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
    end

    assign hart_rst_n_o[h] = sync_q[SYNC_STAGES-1];
  end

  assign soft_rst_ack_o = ack_q;
  assign boot_done_o    = boot_done_q;
  assign all_released_o = &hart_rst_n_o;

endmodule

// File: tb/tb_tile_reset_sequencer.sv
// Scoreboard bench for tile_reset_sequencer against an edge-count reference model.
`timescale 1ns/1ps
module tb_tile_reset_sequencer;
  localparam int N    = 4;
  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int STG  = 3;
  localparam int SOFT = 5;
  localparam int E    = 1 << (W - 1);
`ifdef TILE_RST_STAGGER_EN
  localparam int STEP = STG;
`else
  localparam int STEP = 0;
`endif
  localparam int R = E + (N - 1) * STEP;

  logic         clk = 1'b0;
  logic         reset_l = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] ack;
  logic [N-1:0] hart_n;
  logic         boot_done;
  logic         all_rel;

  tile_reset_sequencer #(
    .NUM_HARTS(N), .WAKE_CNT_W(W), .SYNC_STAGES(SYNC),
    .STAGGER_CYCLES(STG), .SOFT_RST_CYCLES(SOFT)
  ) dut (
    .clk_i(clk), .reset_l(reset_l), .soft_rst_req_i(req),
    .soft_rst_ack_o(ack), .hart_rst_n_o(hart_n),
    .boot_done_o(boot_done), .all_released_o(all_rel)
  );

  always #5 clk = ~clk;

  typedef struct {int hart; int edge_n;} ack_t;

  int        tests = 0;
  int        fails = 0;
  int        k = 0;
  int        hold_end [N];
  bit        req_prev [N];
  bit [SYNC:0] hist   [N];
  ack_t      exp_q[$];
  int        rise_hart [N];
  int        rise_boot, rise_all;
  logic [N-1:0] hart_prev;
  logic      boot_prev, all_prev;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, k);
    end
  endtask

  function automatic void model_reset();
    k = 0;
    for (int h = 0; h < N; h++) begin
      hold_end[h]  = 0;
      req_prev[h]  = 1'b0;
      hist[h]      = '0;
      rise_hart[h] = 0;
    end
    rise_boot = 0;
    rise_all  = 0;
    hart_prev = '0;
    boot_prev = 1'b0;
    all_prev  = 1'b0;
    exp_q.delete();
  endfunction

  function automatic logic [N-1:0] exp_hart();
    logic [N-1:0] v;
    for (int h = 0; h < N; h++) v[h] = &hist[h];
    return v;
  endfunction

  // Reference model: what each edge means from the boot and soft-reset rules.
  always @(posedge clk) begin
    if (reset_l) begin
      k++;
      for (int h = 0; h < N; h++) begin
        bit rise;
        bit pre;
        rise = req[h] && !req_prev[h];
        req_prev[h] = req[h];
        if (hold_end[h] != 0 && k == hold_end[h]) begin
          hold_end[h] = 0;
        end else if (hold_end[h] == 0 && k > R && rise) begin
          ack_t a;
          hold_end[h] = k + SOFT;
          a.hart   = h;
          a.edge_n = k + SOFT;
          exp_q.push_back(a);
        end
        pre = (k >= E + h * STEP) && (hold_end[h] == 0);
        hist[h] = {hist[h][SYNC-1:0], pre};
      end
    end
  end

  // Monitor: per-cycle output checks and ack scoreboard.
  always @(negedge clk) begin
    logic [N-1:0] ev;
    ev = reset_l ? exp_hart() : '0;
    check("hart_rst_n", int'(hart_n), int'(ev));
    check("boot_done", int'(boot_done), int'(reset_l && k >= R));
    check("all_released", int'(all_rel), int'(&ev));
    for (int h = 0; h < N; h++) begin
      if (ack[h]) begin
        if (exp_q.size() == 0) begin
          check("ack_spurious", h, -1);
        end else begin
          ack_t a;
          a = exp_q.pop_front();
          check("ack_hart", h, a.hart);
          check("ack_edge", k, a.edge_n);
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0].edge_n < k) begin
      ack_t a;
      a = exp_q.pop_front();
      check("ack_missing_hart", -1, a.hart);
    end
    for (int h = 0; h < N; h++)
      if (hart_n[h] && !hart_prev[h] && rise_hart[h] == 0) rise_hart[h] = k;
    if (boot_done && !boot_prev && rise_boot == 0) rise_boot = k;
    if (all_rel && !all_prev && rise_all == 0) rise_all = k;
    hart_prev = hart_n;
    boot_prev = boot_done;
    all_prev  = all_rel;
  end

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (k < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (k < target) check("run_to_timeout", k, target);
  endtask

  task automatic check_boot_timing();
    for (int h = 0; h < N; h++)
      check($sformatf("rise_hart%0d", h), rise_hart[h], E + h * STEP + SYNC);
    check("rise_boot_done", rise_boot, R);
    check("rise_all_released", rise_all, R + SYNC);
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    req = '0;
    #2;
    reset_l = 1'b0;
    model_reset();
    #1;
    check("abort_hart_rst_n", int'(hart_n), 0);
    check("abort_boot_done", int'(boot_done), 0);
    check("abort_all_released", int'(all_rel), 0);
    check("abort_ack", int'(ack), 0);
    @(negedge clk);
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    @(negedge clk);
    req = req | m;
    @(negedge clk);
    req = req & ~m;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_hart_rst_n", int'(hart_n), 0);
    check("reset_boot_done", int'(boot_done), 0);

    // Boot with requests in WAKE (edge 4) and RELEASE (edge 11).
    reset_l = 1'b1;
    run_to(3);
    req = '1;
    @(negedge clk);
    req = '0;
    run_to(10);
    req = 4'b0101;
    @(negedge clk);
    req = '0;
    run_to(25);
    check_boot_timing();

    // Single soft reset on hart 2, then a level held for 20 cycles, then a re-pulse.
    pulse(4'b0100);
    repeat (10) @(negedge clk);
    @(negedge clk);
    req[1] = 1'b1;
    repeat (20) @(negedge clk);
    req[1] = 1'b0;
    repeat (3) @(negedge clk);
    pulse(4'b0010);
    repeat (10) @(negedge clk);

    // Random request traffic.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int h = 0; h < N; h++)
        if ($urandom_range(0, 5) == 0) req[h] = ~req[h];
    end
    req = '0;
    repeat (10) @(negedge clk);

    // Abort mid-RELEASE, then a clean reboot.
    reset_mid_cycle();
    run_to(12);
    reset_mid_cycle();
    run_to(25);
    check_boot_timing();

    // Abort in the middle of a parallel HOLD: no ack may follow.
    pulse(4'b1001);
    repeat (2) @(negedge clk);
    reset_mid_cycle();
    run_to(30);
    check_boot_timing();

    check("pending_acks", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
